// File: rtl/alu_share_arbiter_if.sv
// Request, ALU and response signals between two requesters, the shared-ALU arbiter and its consumer.
// The slave modport is the arbiter's view; the master modport is the surrounding environment.
interface alu_share_arbiter_if #(
    parameter int unsigned N = 32
);
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic [2:0]   req0_op;

    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [2:0]   req1_op;

    logic [N-1:0] alu_in0;
    logic [N-1:0] alu_in1;
    logic [2:0]   alu_sel;
    logic [N-1:0] alu_out;
    logic         alu_zero;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N-1:0] rsp_result;
    logic         rsp_zero;
    logic         rsp_err;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  alu_out, alu_zero, rsp_ready,
        output req0_ready, req1_ready,
        output alu_in0, alu_in1, alu_sel,
        output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output alu_out, alu_zero, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_in0, alu_in1, alu_sel,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter and sequencer sharing one combinational ALU between two requesters.
// Operands are registered onto the ALU, the result is captured one cycle later and returned tagged.
module alu_share_arbiter #(
    parameter int unsigned N = 32
) (
    input logic                 clk,
    input logic                 rst,
    alu_share_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic         prio;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [2:0]   op_q;
    logic         id_q;

    logic         open_c;
    logic         gnt1_c;
    logic         acc0_c;
    logic         acc1_c;
    logic         accept_c;

    logic         rsp_valid_q;
    logic         rsp_id_q;
    logic [N-1:0] rsp_result_q;
    logic         rsp_zero_q;
    logic         rsp_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Grant and next state; readies are held low throughout reset
    always_comb begin
        state_nx = state;
        open_c   = 1'b0;
        gnt1_c   = bus.req1_valid && (!bus.req0_valid || prio);
        case (state)
            IDLE:    open_c = 1'b1;
            RESP:    open_c = bus.rsp_ready;
            default: open_c = 1'b0;
        endcase
        if (rst) begin
            open_c = 1'b0;
        end
        acc1_c   = open_c && gnt1_c;
        acc0_c   = open_c && bus.req0_valid && !gnt1_c;
        accept_c = acc0_c || acc1_c;
        case (state)
            IDLE: begin
                if (accept_c) state_nx = EXEC;
            end
            EXEC: state_nx = RESP;
            RESP: begin
                if (bus.rsp_ready) state_nx = accept_c ? EXEC : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture and round-robin pointer update on each accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 1'b0;
            a_q  <= '0;
            b_q  <= '0;
            op_q <= 3'b000;
            id_q <= 1'b0;
        end else if (accept_c) begin
            prio <= acc0_c;
            a_q  <= acc1_c ? bus.req1_a  : bus.req0_a;
            b_q  <= acc1_c ? bus.req1_b  : bus.req0_b;
            op_q <= acc1_c ? bus.req1_op : bus.req0_op;
            id_q <= acc1_c;
        end
    end

    // Result capture at the end of EXEC; illegal ops bypass the ALU output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            rsp_valid_q <= (state_nx == RESP);
            if (state == EXEC) begin
                rsp_id_q <= id_q;
                if (op_q[2]) begin
                    rsp_result_q <= '0;
                    rsp_zero_q   <= 1'b0;
                    rsp_err_q    <= 1'b1;
                end else begin
                    rsp_result_q <= bus.alu_out;
                    rsp_zero_q   <= bus.alu_zero;
                    rsp_err_q    <= 1'b0;
                end
            end
        end
    end

    assign bus.req0_ready = acc0_c;
    assign bus.req1_ready = acc1_c;
    assign bus.alu_in0    = a_q;
    assign bus.alu_in1    = b_q;
    assign bus.alu_sel    = op_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU standing in for the real datapath.
// Expected values are hand-computed constants checked with immediate assertions.
module tb_alu_share_arbiter;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    alu_share_arbiter_if #(.N(32)) bus ();

    alu_share_arbiter #(.N(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in ALU: 000 add, 001 sub, 010 and, 011 or
    always_comb begin
        case (bus.alu_sel)
            3'b000:  bus.alu_out = bus.alu_in0 + bus.alu_in1;
            3'b001:  bus.alu_out = bus.alu_in0 - bus.alu_in1;
            3'b010:  bus.alu_out = bus.alu_in0 & bus.alu_in1;
            3'b011:  bus.alu_out = bus.alu_in0 | bus.alu_in1;
            default: bus.alu_out = 32'h0;
        endcase
        bus.alu_zero = (bus.alu_out == 32'h0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [31:0] exp_res [4];
    logic [2:0]  exp_sel [4];
    logic        exp_id  [4];

    initial begin
        vectors = 0;
        errors  = 0;
        exp_res = '{32'h0000_F000, 32'h0000_FFFF, 32'h0000_F000, 32'h0000_FFFF};
        exp_sel = '{3'b010, 3'b011, 3'b010, 3'b011};
        exp_id  = '{1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 32'd5; bus.req0_b = 32'd3; bus.req0_op = 3'b000;
        bus.req1_valid = 1'b0; bus.req1_a = 32'd0; bus.req1_b = 32'd0; bus.req1_op = 3'b000;
        bus.rsp_ready  = 1'b0;

        // Reset state, with a valid request present that must not be readied
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",  32'(bus.rsp_valid), 32'd0);
        chk("rst_result", bus.rsp_result,     32'd0);
        chk("rst_in0",    bus.alu_in0,        32'd0);
        chk("rst_sel",    32'(bus.alu_sel),   32'd0);
        chk("rst_ready0", 32'(bus.req0_ready), 32'd0);

        // req0: 5 + 3
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t1_ready0", 32'(bus.req0_ready), 32'd1);
        chk("t1_ready1", 32'(bus.req1_ready), 32'd0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        chk("t1_in0",   bus.alu_in0, 32'd5);
        chk("t1_in1",   bus.alu_in1, 32'd3);
        chk("t1_exec_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("t1_valid",  32'(bus.rsp_valid),  32'd1);
        chk("t1_result", bus.rsp_result,      32'd8);
        chk("t1_zero",   32'(bus.rsp_zero),   32'd0);
        chk("t1_id",     32'(bus.rsp_id),     32'd0);
        chk("t1_err",    32'(bus.rsp_err),    32'd0);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        chk("t1_idle_valid", 32'(bus.rsp_valid), 32'd0);

        // req1: 7 - 7 held under backpressure
        bus.req1_valid = 1'b1; bus.req1_a = 32'd7; bus.req1_b = 32'd7; bus.req1_op = 3'b001;
        #1;
        chk("t2_ready1", 32'(bus.req1_ready), 32'd1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        @(posedge clk); #1;
        chk("t2_valid",  32'(bus.rsp_valid), 32'd1);
        chk("t2_result", bus.rsp_result,     32'd0);
        chk("t2_zero",   32'(bus.rsp_zero),  32'd1);
        chk("t2_id",     32'(bus.rsp_id),    32'd1);
        bus.req0_valid = 1'b1; bus.req0_a = 32'h0000_F0F0; bus.req0_b = 32'h0000_FF00; bus.req0_op = 3'b010;
        bus.req1_valid = 1'b1; bus.req1_a = 32'h0000_F0F0; bus.req1_b = 32'h0000_0F0F; bus.req1_op = 3'b011;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_hold_ready0", 32'(bus.req0_ready), 32'd0);
            chk("t2_hold_ready1", 32'(bus.req1_ready), 32'd0);
            chk("t2_hold_valid",  32'(bus.rsp_valid),  32'd1);
            chk("t2_hold_result", bus.rsp_result,      32'd0);
            @(posedge clk); #1;
        end

        // Both requesters streaming: grants alternate starting with req0
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t3_grant0", 32'(bus.req0_ready), 32'(!exp_id[i]));
            chk("t3_grant1", 32'(bus.req1_ready), 32'(exp_id[i]));
            @(posedge clk); #1;
            if (i == 3) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            chk("t3_exec_valid", 32'(bus.rsp_valid), 32'd0);
            chk("t3_sel",        32'(bus.alu_sel),   32'(exp_sel[i]));
            @(posedge clk); #1;
            chk("t3_valid",  32'(bus.rsp_valid), 32'd1);
            chk("t3_result", bus.rsp_result,     exp_res[i]);
            chk("t3_id",     32'(bus.rsp_id),    32'(exp_id[i]));
        end

        // Illegal op, then a legal one (0x10 - 4)
        bus.req0_valid = 1'b1; bus.req0_a = 32'd9; bus.req0_b = 32'd9; bus.req0_op = 3'b101;
        #1;
        chk("t4_ready0", 32'(bus.req0_ready), 32'd1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        chk("t4_sel", 32'(bus.alu_sel), 32'd5);
        @(posedge clk); #1;
        chk("t4_valid",  32'(bus.rsp_valid), 32'd1);
        chk("t4_err",    32'(bus.rsp_err),   32'd1);
        chk("t4_result", bus.rsp_result,     32'd0);
        chk("t4_zero",   32'(bus.rsp_zero),  32'd0);
        bus.req1_valid = 1'b1; bus.req1_a = 32'h10; bus.req1_b = 32'h4; bus.req1_op = 3'b001;
        #1;
        chk("t4_ready1", 32'(bus.req1_ready), 32'd1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        @(posedge clk); #1;
        chk("t4b_result", bus.rsp_result,    32'hC);
        chk("t4b_err",    32'(bus.rsp_err),  32'd0);
        chk("t4b_zero",   32'(bus.rsp_zero), 32'd0);
        chk("t4b_id",     32'(bus.rsp_id),   32'd1);

        // Reset during EXEC
        bus.req0_valid = 1'b1; bus.req0_a = 32'h11; bus.req0_b = 32'h22; bus.req0_op = 3'b011;
        #1;
        chk("t5_ready0", 32'(bus.req0_ready), 32'd1);
        @(posedge clk); #1;
        chk("t5_exec_in0", bus.alu_in0, 32'h11);
        rst = 1'b1;
        #1;
        chk("t5_rst_in0",    bus.alu_in0,         32'd0);
        chk("t5_rst_in1",    bus.alu_in1,         32'd0);
        chk("t5_rst_sel",    32'(bus.alu_sel),    32'd0);
        chk("t5_rst_valid",  32'(bus.rsp_valid),  32'd0);
        chk("t5_rst_ready0", 32'(bus.req0_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.rsp_ready = 1'b0;
        #1;
        chk("t5_rel_ready0", 32'(bus.req0_ready), 32'd1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        chk("t5_valid",  32'(bus.rsp_valid), 32'd1);
        chk("t5_result", bus.rsp_result,     32'h33);

        // Reset during RESP
        rst = 1'b1;
        #1;
        chk("t6_rst_valid",  32'(bus.rsp_valid), 32'd0);
        chk("t6_rst_result", bus.rsp_result,     32'd0);
        chk("t6_rst_in0",    bus.alu_in0,        32'd0);
        chk("t6_rst_sel",    32'(bus.alu_sel),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 32'd1;          bus.req0_b = 32'd1; bus.req0_op = 3'b000;
        bus.req1_valid = 1'b1; bus.req1_a = 32'hFFFF_FFFF; bus.req1_b = 32'd1; bus.req1_op = 3'b000;
        #1;
        chk("t6_prio_ready0", 32'(bus.req0_ready), 32'd1);
        chk("t6_prio_ready1", 32'(bus.req1_ready), 32'd0);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(posedge clk); #1;
        chk("t6_r0_result", bus.rsp_result,  32'd2);
        chk("t6_r0_id",     32'(bus.rsp_id), 32'd0);
        #1;
        chk("t6_ready1", 32'(bus.req1_ready), 32'd1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0;
        @(posedge clk); #1;
        chk("t6_r1_valid",  32'(bus.rsp_valid), 32'd1);
        chk("t6_r1_result", bus.rsp_result,     32'd0);
        chk("t6_r1_zero",   32'(bus.rsp_zero),  32'd1);
        chk("t6_r1_id",     32'(bus.rsp_id),    32'd1);
        chk("t6_r1_err",    32'(bus.rsp_err),   32'd0);
        @(posedge clk); #1;
        chk("t6_idle_valid", 32'(bus.rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
